// File: rtl/bscan_dr_generic.sv
// Fixed-length JTAG USER data register behind bscan_generic, clocked by TCK.
// Scans carry {payload, overrun, upd_valid}; only exact-length scans commit to the fabric.
module bscan_dr_generic #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sel,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             tdi,
  output logic             tdo,
  input  logic [WIDTH-1:0] cap_data,
  output logic [WIDTH-1:0] upd_data,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic             overrun
);

  localparam int              CW       = $clog2(WIDTH + 4);
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH + 2);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(WIDTH + 3);

  logic [WIDTH+1:0] sr;
  logic [CW-1:0]    cnt;
  logic             do_cap;
  logic             do_shift;
  logic             do_upd;
  logic             commit;
  logic             consume;

  // Capture outranks shift, shift outranks update, all gated by sel.
  assign do_cap   = sel & capture;
  assign do_shift = sel & shift & ~capture;
  assign do_upd   = sel & update & ~capture & ~shift;
  assign commit   = do_upd && (cnt == CNT_FULL);
  assign consume  = upd_valid & upd_ready;

  assign tdo = sr[0];

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr  <= '0;
      cnt <= '0;
    end else if (do_cap) begin
      sr  <= {cap_data, overrun, upd_valid};
      cnt <= '0;
    end else if (do_shift) begin
      sr <= {tdi, sr[WIDTH+1:1]};
      // Saturate so an over-long scan can never wrap back to the commit length.
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upd_data  <= RESET_VAL;
      upd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (commit) begin
        upd_data  <= sr[WIDTH+1:2];
        upd_valid <= 1'b1;
        if (upd_valid && !upd_ready) overrun <= 1'b1;
      end else if (consume) begin
        upd_valid <= 1'b0;
      end
      // The old flag has already been copied into sr[1] on this edge.
      if (do_cap) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bscan_dr_generic.sv
// Directed bench for bscan_dr_generic at WIDTH=8: write, readback, length check,
// overrun, simultaneous consume/commit, async reset mid-scan and sel gating.
module tb_bscan_dr_generic;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'h5A;

  logic             clk = 1'b0;
  logic             rstn;
  logic             sel, capture, shift, update, tdi, upd_ready;
  logic             tdo, upd_valid, overrun;
  logic [WIDTH-1:0] cap_data, upd_data;

  int total = 0;
  int bad   = 0;

  bscan_dr_generic #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sel       (sel),
    .capture   (capture),
    .shift     (shift),
    .update    (update),
    .tdi       (tdi),
    .tdo       (tdo),
    .cap_data  (cap_data),
    .upd_data  (upd_data),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One TCK cycle: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic s, input logic c, input logic sh, input logic u,
                      input logic t, input logic r);
    @(negedge clk);
    sel = s; capture = c; shift = sh; update = u; tdi = t; upd_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Full host write: capture, nshift shifts of {payload, 2'b00} LSB first, update.
  task automatic host_write(input logic [7:0] payload, input int nshift, input logic rdy);
    logic [9:0] vec;
    vec = {payload, 2'b00};
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < nshift; i++)
      step(1, 0, 1, 0, (i < 10) ? vec[i] : 1'b0, 0);
    step(1, 0, 0, 1, 0, rdy);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic v, input logic o);
    check({tag, "_data"},    32'(upd_data),  32'(d));
    check({tag, "_valid"},   32'(upd_valid), 32'(v));
    check({tag, "_overrun"}, 32'(overrun),   32'(o));
  endtask

  initial begin
    logic [9:0] exp_rd;
    logic [9:0] vec;

    rstn = 1'b0; sel = 0; capture = 0; shift = 0; update = 0; tdi = 0; upd_ready = 0;
    cap_data = 8'h3C;
    #12;
    check("rst_tdo", 32'(tdo), 32'd0);
    check_outs("rst", RV, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    step(1, 0, 0, 0, 0, 0);

    // Basic write, fabric not ready.
    host_write(8'hA5, 10, 1'b0);
    check_outs("wr_a5", 8'hA5, 1'b1, 1'b0);

    // Readback: status {overrun=0, valid=1} then cap_data LSB first.
    exp_rd = {8'h3C, 1'b0, 1'b1};
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rd_tdo%0d", i), 32'(tdo), 32'(exp_rd[i]));
      step(1, 0, 1, 0, 0, 0);
    end
    check_outs("rd_after", 8'hA5, 1'b1, 1'b0);

    // Short, long and far-too-long scans never commit (the last would wrap an unsaturated counter).
    host_write(8'hFF, 9, 1'b0);
    check_outs("short", 8'hA5, 1'b1, 1'b0);
    host_write(8'hFF, 11, 1'b0);
    check_outs("long", 8'hA5, 1'b1, 1'b0);
    host_write(8'hFF, 26, 1'b0);
    check_outs("wrap", 8'hA5, 1'b1, 1'b0);

    // Overrun: commit over an unconsumed payload.
    host_write(8'h11, 10, 1'b0);
    check_outs("ovr", 8'h11, 1'b1, 1'b1);
    step(1, 1, 0, 0, 0, 0);
    check("ovr_cap_tdo0", 32'(tdo), 32'd1);
    check("ovr_cleared", 32'(overrun), 32'd0);
    step(1, 0, 1, 0, 0, 0);
    check("ovr_cap_tdo1", 32'(tdo), 32'd1);

    // Commit on the same edge the fabric consumes.
    host_write(8'h22, 10, 1'b1);
    check_outs("simul", 8'h22, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0, 1);
    check_outs("consume", 8'h22, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a scan.
    host_write(8'h33, 10, 1'b0);
    check_outs("pre_rst", 8'h33, 1'b1, 1'b0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1, 0);
    check("pre_rst_tdo", 32'(tdo), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_tdo", 32'(tdo), 32'd0);
    check_outs("mid_rst", RV, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1; shift = 0;
    step(1, 0, 0, 0, 0, 0);
    check_outs("post_rst", RV, 1'b0, 1'b0);

    // sel gating: gated pulses between real shifts must not move sr or cnt.
    host_write(8'h44, 10, 1'b0);
    check_outs("gate_pre", 8'h44, 1'b1, 1'b0);
    vec = {8'h66, 2'b00};
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, vec[i], 0);
    check("gate_tdo_a", 32'(tdo), 32'd0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    check("gate_tdo_b", 32'(tdo), 32'd0);
    check_outs("gate_mid", 8'h44, 1'b1, 1'b0);
    for (int i = 3; i < 10; i++) step(1, 0, 1, 0, vec[i], 0);
    step(1, 0, 0, 1, 0, 0);
    check_outs("gate_commit", 8'h66, 1'b1, 1'b1);

    // Handshake keeps running while sel is low.
    step(0, 0, 0, 0, 0, 1);
    check_outs("gate_consume", 8'h66, 1'b0, 1'b1);

    step(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
